// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel position, display enable and timing lock
// from active-low hsync/vsync that arrive synchronous to the pixel clock.
//
// Ports:
//   vga_clk      in   pixel clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   hsync_in     in   horizontal sync, active-low
//   vsync_in     in   vertical sync, active-low
//   x_pos        out  recovered column (one clock behind the source counter)
//   y_pos        out  recovered line
//   de           out  display enable, only while locked and inside active area
//   locked       out  timing has matched the parameters for LOCK_FRAMES frames
//   line_len     out  last measured line length in clocks
//   frame_lines  out  last measured frame length in lines
//   err          out  one-cycle pulse on any timing violation while tracking
module vga_sync_decoder #(
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP_END    = 144,
  parameter int unsigned H_ACT_END   = 784,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP_END    = 35,
  parameter int unsigned V_ACT_END   = 515,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        vga_clk,
  input  logic        rst_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic        de,
  output logic        locked,
  output logic [11:0] line_len,
  output logic [11:0] frame_lines,
  output logic        err
);

  localparam int unsigned CW = 12;
  localparam int unsigned GW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

  localparam logic [CW-1:0] CNT_MAX     = '1;
  localparam logic [CW:0]   H_TOTAL_C   = (CW+1)'(H_TOTAL);
  localparam logic [CW:0]   V_TOTAL_C   = (CW+1)'(V_TOTAL);
  localparam logic [CW:0]   H_SYNC_C    = (CW+1)'(H_SYNC);
  localparam logic [CW-1:0] H_BP_C      = CW'(H_BP_END);
  localparam logic [CW-1:0] H_ACT_C     = CW'(H_ACT_END);
  localparam logic [CW-1:0] V_BP_C      = CW'(V_BP_END);
  localparam logic [CW-1:0] V_ACT_C     = CW'(V_ACT_END);
  localparam logic [GW:0]   LOCK_C      = (GW+1)'(LOCK_FRAMES);

  // vsync width is informational only; nothing in the tracker checks it
  localparam int unsigned vsync_width_unused = V_SYNC;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            h_prev;
  logic            v_prev;
  logic [GW-1:0]   good_cnt;
  logic [GW-1:0]   good_nxt;
  logic            started;
  logic            started_nxt;

  logic            hfall;
  logic            hrise;
  logic            vfall;
  logic            frame_edge;
  logic [CW:0]     x_inc;
  logic [CW:0]     y_inc;
  logic [CW-1:0]   x_sat;
  logic [CW-1:0]   y_sat;
  logic [CW-1:0]   x_nxt;
  logic [CW-1:0]   y_nxt;
  logic [CW-1:0]   line_len_nxt;
  logic [CW-1:0]   frame_lines_nxt;
  logic [GW:0]     good_inc;
  logic            viol_len;
  logic            viol_miss;
  logic            viol_vodd;
  logic            viol_frame;
  logic            viol_width;
  logic            viol;
  logic            de_nxt;

  // Sync edge detection against the previous sampled level
  always_comb begin
    hfall      = h_prev & ~hsync_in;
    hrise      = ~h_prev & hsync_in;
    vfall      = v_prev & ~vsync_in;
    frame_edge = hfall & vfall;
  end

  // Position counters and measurements; the unsaturated x_inc/y_inc are the
  // "count plus one" values the timing checks compare against
  always_comb begin
    x_inc = {1'b0, x_pos} + (CW+1)'(1);
    y_inc = {1'b0, y_pos} + (CW+1)'(1);
    x_sat = (x_pos == CNT_MAX) ? x_pos : x_inc[CW-1:0];
    y_sat = (y_pos == CNT_MAX) ? y_pos : y_inc[CW-1:0];

    x_nxt = hfall ? '0 : x_sat;

    y_nxt = y_pos;
    if (frame_edge) begin
      y_nxt = '0;
    end else if (hfall) begin
      y_nxt = y_sat;
    end

    line_len_nxt    = hfall      ? x_sat : line_len;
    frame_lines_nxt = frame_edge ? y_sat : frame_lines;
  end

  // Timing violations; only meaningful once a frame boundary has been seen
  always_comb begin
    viol_len   = hfall && (x_inc != H_TOTAL_C);
    // x_inc is unsaturated, so this fires once, on the clock x_pos becomes H_TOTAL
    viol_miss  = !hfall && (x_inc == H_TOTAL_C);
    viol_vodd  = vfall && !hfall;
    viol_frame = frame_edge && (y_inc != V_TOTAL_C);
    viol_width = hrise && (x_inc != H_SYNC_C);
    viol       = (state != SEARCH) &&
                 (viol_len | viol_miss | viol_vodd | viol_frame | viol_width);
  end

  // Lock tracker next state; the first boundary seen in MEASURE only arms counting
  always_comb begin
    state_nxt   = state;
    good_nxt    = good_cnt;
    started_nxt = started;
    good_inc    = {1'b0, good_cnt} + (GW+1)'(1);
    case (state)
      SEARCH: begin
        if (frame_edge) begin
          state_nxt   = MEASURE;
          good_nxt    = '0;
          started_nxt = 1'b0;
        end
      end
      MEASURE: begin
        if (viol) begin
          state_nxt = SEARCH;
        end else if (frame_edge) begin
          if (!started) begin
            started_nxt = 1'b1;
          end else begin
            good_nxt = good_inc[GW-1:0];
            if (good_inc >= LOCK_C) begin
              state_nxt = LOCKED;
            end
          end
        end
      end
      LOCKED: begin
        if (viol) begin
          state_nxt = SEARCH;
        end
      end
      default: begin
        state_nxt = SEARCH;
      end
    endcase
  end

  // Display enable built from next-state values so it lines up with x_pos/y_pos
  always_comb begin
    de_nxt = (state_nxt == LOCKED) &&
             (x_nxt >= H_BP_C) && (x_nxt < H_ACT_C) &&
             (y_nxt >= V_BP_C) && (y_nxt < V_ACT_C);
  end

  // State and output registers
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_prev      <= 1'b1;
      v_prev      <= 1'b1;
      x_pos       <= '0;
      y_pos       <= '0;
      line_len    <= '0;
      frame_lines <= '0;
      de          <= 1'b0;
      locked      <= 1'b0;
      err         <= 1'b0;
      state       <= SEARCH;
      good_cnt    <= '0;
      started     <= 1'b0;
    end else begin
      h_prev      <= hsync_in;
      v_prev      <= vsync_in;
      x_pos       <= x_nxt;
      y_pos       <= y_nxt;
      line_len    <= line_len_nxt;
      frame_lines <= frame_lines_nxt;
      de          <= de_nxt;
      locked      <= (state_nxt == LOCKED);
      err         <= viol;
      state       <= state_nxt;
      good_cnt    <= good_nxt;
      started     <= started_nxt;
    end
  end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameters (name, default, meaning), one per line:
 H_SYNC 96: hsync low width, clocks.
 H_BP_END 144: first active x.
 H_ACT_END 784: first x after active.
 H_TOTAL 800: clocks per line.
 V_SYNC 2: vsync low width, lines.
 V_BP_END 35: first active y.
 V_ACT_END 515: first y after active.
 V_TOTAL 525: lines per frame.
 LOCK_FRAMES 2: consecutive good frames to lock.
REQ-002 Ports (name, direction, width, meaning), one per line:
 vga_clk  in  1  pixel clock; all logic on its rising edge.
 rst_n  in  1  reset; asynchronous, active-low.
 hsync_in  in  1  horizontal sync, active-low, synchronous to vga_clk.
 vsync_in  in  1  vertical sync, active-low, synchronous to vga_clk.
 x_pos  out  12  recovered column.
 y_pos  out  12  recovered line.
 de  out  1  recovered display enable.
 locked  out  1  timing matches parameters.
 line_len  out  12  last measured line length, clocks.
 frame_lines  out  12  last measured frame length, lines.
 err  out  1  one-cycle timing-violation pulse.

Function
REQ-003 All outputs SHALL be registered; inputs SHALL be registered once into h_prev/v_prev for edge detection.
REQ-004 hfall SHALL be h_prev=1 and hsync_in=0 at a clock edge; vfall likewise for vsync.
REQ-005 On hfall, x_pos SHALL load 0; otherwise x_pos SHALL increment, saturating at 4095.
REQ-006 On hfall, line_len SHALL load x_pos+1 (pre-reset value plus one), saturating at 4095.
REQ-007 On hfall with vfall, y_pos SHALL load 0 and frame_lines SHALL load y_pos+1; on hfall without vfall, y_pos SHALL increment, saturating at 4095; y_pos SHALL hold otherwise.
REQ-008 Latency: x_pos SHALL read 0 in the cycle after the first sampled-low hsync cycle (one clock behind the source counter).
REQ-009 FSM states SEARCH, MEASURE, LOCKED; reset state SEARCH.
REQ-010 SEARCH -> MEASURE on hfall with vfall; good-frame counter cleared.
REQ-011 Violations, checked in MEASURE and LOCKED only:
 (a) hfall with x_pos+1 != H_TOTAL;
 (b) x_pos reaches H_TOTAL without hfall (missing hsync);
 (c) vfall without coincident hfall;
 (d) hfall-with-vfall with y_pos+1 != V_TOTAL;
 (e) hsync rising edge with x_pos+1 != H_SYNC.
REQ-012 Any violation SHALL pulse err for exactly one cycle and move the FSM to SEARCH; locked SHALL drop in the same cycle err asserts; multiple violations in one cycle give one pulse.
REQ-013 In MEASURE, each violation-free hfall-with-vfall SHALL increment the good-frame counter; on reaching LOCK_FRAMES, the FSM SHALL enter LOCKED; locked=1 exactly in LOCKED.
REQ-014 The first frame boundary after entering MEASURE starts measurement and SHALL NOT count as a good frame.
REQ-015 de SHALL be 1 only when locked, H_BP_END<=x_pos<H_ACT_END and V_BP_END<=y_pos<V_ACT_END, evaluated on the registered next-state values so de aligns with x_pos/y_pos.
REQ-016 In SEARCH, counters and measurements SHALL keep running; err SHALL stay 0.
REQ-017 Glitch-free input is assumed at the protocol level; no metastability synchronisers are included (same clock domain as the source).

Reset
REQ-018 While rst_n=0: x_pos, y_pos, line_len, frame_lines = 0; de, locked, err = 0; h_prev, v_prev = 1; FSM = SEARCH; good-frame counter = 0.
REQ-019 Reset asserted mid-frame SHALL clear state immediately; after release, lock requires a fresh SEARCH->MEASURE->LOCKED sequence.

Verification
REQ-020 Nominal 800x525 source, sync active-low, from reset -> locked rises at the 3rd frame boundary after the first vfall; line_len=800, frame_lines=525; err never pulses.
REQ-021 Locked, source x=144,y=35 -> decoder shows x_pos=144, y_pos=35, de=1 one clock later; at x_pos=784, de=0.
REQ-022 Locked, one line shortened to 799 clocks -> err pulses once at that hfall, line_len=799, locked=0, relock after 2 good frames.
REQ-023 Locked, hsync held high -> err when x_pos reaches 800; x_pos continues, saturates at 4095.
REQ-024 Locked, hsync low width 95 -> err on rising edge; vsync falling 10 clocks after hsync fall -> err.
REQ-025 rst_n pulsed low mid-frame while locked -> all outputs 0 asynchronously; locked stays 0 until 2 good frames after resync.
